// File: rtl/accel_avg_sequencer.sv
// Block-averages 2^LOG2_AVG accelerometer updates per axis, valid/ready out.
// Optional stale-input timeout enabled by defining ACCEL_STALE_EN.
module accel_avg_sequencer #(
  parameter int LOG2_AVG       = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                data_update,
  input  logic [15:0]         data_x,
  input  logic [15:0]         data_y,
  input  logic [15:0]         data_z,
  output logic [15:0]         avg_x,
  output logic [15:0]         avg_y,
  output logic [15:0]         avg_z,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic [LOG2_AVG-1:0] sample_cnt,
  output logic                overrun,
  input  logic                clear_ovr
`ifdef ACCEL_STALE_EN
  ,
  output logic                stale
`endif
);

  localparam int AW = 16 + LOG2_AVG;

  if (LOG2_AVG < 1 || LOG2_AVG > 6 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("accel_avg_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;

  logic data_update_d;
  logic upd_edge;

  logic signed [AW-1:0] acc_x;
  logic signed [AW-1:0] acc_y;
  logic signed [AW-1:0] acc_z;

  logic signed [AW-1:0] ext_x;
  logic signed [AW-1:0] ext_y;
  logic signed [AW-1:0] ext_z;

  logic signed [AW-1:0] sh_x;
  logic signed [AW-1:0] sh_y;
  logic signed [AW-1:0] sh_z;

  assign upd_edge = data_update & ~data_update_d;

  assign ext_x = {{LOG2_AVG{data_x[15]}}, data_x};
  assign ext_y = {{LOG2_AVG{data_y[15]}}, data_y};
  assign ext_z = {{LOG2_AVG{data_z[15]}}, data_z};

  // Sum of N 16-bit samples shifted back by LOG2_AVG always fits 16 bits.
  assign sh_x = acc_x >>> LOG2_AVG;
  assign sh_y = acc_y >>> LOG2_AVG;
  assign sh_z = acc_z >>> LOG2_AVG;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      data_update_d <= 1'b0;
      acc_x         <= '0;
      acc_y         <= '0;
      acc_z         <= '0;
      avg_x         <= '0;
      avg_y         <= '0;
      avg_z         <= '0;
      avg_valid     <= 1'b0;
      sample_cnt    <= '0;
      overrun       <= 1'b0;
    end else begin
      data_update_d <= data_update;
      if (clear_ovr) overrun <= 1'b0;
      if (avg_valid && avg_ready) avg_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          acc_x      <= '0;
          acc_y      <= '0;
          acc_z      <= '0;
          sample_cnt <= '0;
          if (enable) state <= ACCUM;
        end
        ACCUM: begin
          if (!enable) begin
            state      <= IDLE;
            acc_x      <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            sample_cnt <= '0;
          end else if (upd_edge) begin
            acc_x      <= acc_x + ext_x;
            acc_y      <= acc_y + ext_y;
            acc_z      <= acc_z + ext_z;
            sample_cnt <= sample_cnt + 1'b1;
            if (&sample_cnt) state <= DONE;
          end
        end
        DONE: begin
          avg_x     <= sh_x[15:0];
          avg_y     <= sh_y[15:0];
          avg_z     <= sh_z[15:0];
          avg_valid <= 1'b1;
          if (avg_valid && !avg_ready) overrun <= 1'b1;
          // An update landing here opens the next window instead of being lost.
          if (enable && upd_edge) begin
            acc_x      <= ext_x;
            acc_y      <= ext_y;
            acc_z      <= ext_z;
            sample_cnt <= LOG2_AVG'(1);
          end else begin
            acc_x      <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            sample_cnt <= '0;
          end
          state <= enable ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACCEL_STALE_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stale_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stale_cnt <= '0;
    end else if (state == IDLE || upd_edge) begin
      stale_cnt <= '0;
    end else if (stale_cnt < SW'(TIMEOUT_CYCLES)) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign stale = (stale_cnt == SW'(TIMEOUT_CYCLES));
`endif

endmodule

// File: tb/tb_accel_avg_sequencer.sv
// Directed bench for accel_avg_sequencer with an arithmetic reference model.
// Define ACCEL_STALE_EN to also exercise the stale timeout.
module tb_accel_avg_sequencer;

  localparam int L = 2;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         data_update = 1'b0;
  logic [15:0]  data_x = '0;
  logic [15:0]  data_y = '0;
  logic [15:0]  data_z = '0;
  logic         avg_ready = 1'b0;
  logic         clear_ovr = 1'b0;
  logic [15:0]  avg_x;
  logic [15:0]  avg_y;
  logic [15:0]  avg_z;
  logic         avg_valid;
  logic [L-1:0] sample_cnt;
  logic         overrun;
`ifdef ACCEL_STALE_EN
  logic         stale;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #20 clk = ~clk;

  accel_avg_sequencer #(
    .LOG2_AVG(L),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .data_update(data_update),
    .data_x(data_x),
    .data_y(data_y),
    .data_z(data_z),
    .avg_x(avg_x),
    .avg_y(avg_y),
    .avg_z(avg_z),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .sample_cnt(sample_cnt),
    .overrun(overrun),
    .clear_ovr(clear_ovr)
`ifdef ACCEL_STALE_EN
    ,
    .stale(stale)
`endif
  );

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Floor division by the window size, independent of any shifting.
  function automatic int fdiv(int s);
    int q;
    q = s / N;
    if ((s % N != 0) && s < 0) q = q - 1;
    return q;
  endfunction

  // Reference model: running sums, sample count, pending-result flag.
  bit          m_run, m_pend, m_prev, m_v, m_o, m_e;
  int          m_cnt, m_sx, m_sy, m_sz;
  logic [15:0] m_ax, m_ay, m_az;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_pend = 0; m_prev = 0; m_v = 0; m_o = 0;
      m_cnt = 0; m_sx = 0; m_sy = 0; m_sz = 0;
      m_ax = '0; m_ay = '0; m_az = '0;
    end else begin
      m_e = data_update && !m_prev;
      m_prev = data_update;
      if (clear_ovr) m_o = 0;
      if (m_pend) begin
        m_ax = 16'(fdiv(m_sx));
        m_ay = 16'(fdiv(m_sy));
        m_az = 16'(fdiv(m_sz));
        if (m_v && !avg_ready) m_o = 1;
        m_v = 1;
        m_pend = 0;
        m_run = enable;
        m_sx = 0; m_sy = 0; m_sz = 0; m_cnt = 0;
        if (enable && m_e) begin
          m_sx = int'($signed(data_x));
          m_sy = int'($signed(data_y));
          m_sz = int'($signed(data_z));
          m_cnt = 1;
        end
      end else begin
        if (m_v && avg_ready) m_v = 0;
        if (!m_run) begin
          m_run = enable;
        end else if (!enable) begin
          m_run = 0;
          m_sx = 0; m_sy = 0; m_sz = 0; m_cnt = 0;
        end else if (m_e) begin
          m_sx += int'($signed(data_x));
          m_sy += int'($signed(data_y));
          m_sz += int'($signed(data_z));
          m_cnt++;
          if (m_cnt == N) begin
            m_pend = 1;
            m_cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_avg", {avg_x, avg_y, avg_z}, {m_ax, m_ay, m_az});
      check("model_valid", avg_valid, m_v);
      check("model_cnt", sample_cnt, m_cnt);
      check("model_ovr", overrun, m_o);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(logic [15:0] x, logic [15:0] y, logic [15:0] z);
    data_x = x; data_y = y; data_z = z;
    data_update = 1'b1;
    tick();
    data_update = 1'b0;
    tick();
  endtask

  task automatic accept();
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
  endtask

  initial begin
    tick(2);
    reset_n = 1'b1;
    tick();
    check("reset_state", {avg_x, avg_y, avg_z, avg_valid, overrun, sample_cnt}, 0);

    pulse(16'd5, 16'd5, 16'd5);
    check("idle_ignore", sample_cnt, 0);

    enable = 1'b1;
    tick(2);
    pulse(16'd10, -16'sd1, 16'h7FFF);
    pulse(16'd20, -16'sd2, 16'h7FFF);
    pulse(16'd30, -16'sd3, 16'h7FFF);
    data_x = 16'd40; data_y = -16'sd4; data_z = 16'h7FFF;
    data_update = 1'b1;
    tick();
    check("lat_one_clk", avg_valid, 0);
    data_update = 1'b0;
    tick();
    check("lat_two_clk", avg_valid, 1);
    check("avg_x_25", avg_x, 16'd25);
    check("avg_y_m3", avg_y, 16'hFFFD);
    check("avg_z_max", avg_z, 16'h7FFF);

    repeat (N) pulse(16'd4, 16'd4, 16'd4);
    check("ovr_set", overrun, 1);
    check("ovr_new_x", avg_x, 16'd4);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("ovr_clear", overrun, 0);
    accept();
    check("accept_drop", avg_valid, 0);

    repeat (N) pulse(16'd1, 16'd1, 16'd1);
    repeat (N - 1) pulse(16'd3, -16'sd3, 16'd3);
    data_x = 16'd3; data_y = -16'sd3; data_z = 16'd3;
    data_update = 1'b1;
    tick();
    data_update = 1'b0;
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    check("simul_valid", avg_valid, 1);
    check("simul_x", avg_x, 16'd3);
    check("simul_ovr", overrun, 0);
    accept();

    pulse(16'd9, 16'd9, 16'd9);
    pulse(16'd9, 16'd9, 16'd9);
    check("partial_cnt", sample_cnt, 2);
    enable = 1'b0;
    tick();
    check("drop_cnt", sample_cnt, 0);
    check("drop_valid", avg_valid, 0);
    enable = 1'b1;
    tick(2);
    repeat (N) pulse(16'd8, 16'd8, 16'd8);
    check("reen_x", avg_x, 16'd8);
    accept();

    data_x = 16'd16; data_y = 16'd16; data_z = 16'd16;
    data_update = 1'b1;
    tick(10);
    data_update = 1'b0;
    tick();
    check("level_one", sample_cnt, 1);
    repeat (N - 1) pulse(16'd16, 16'd16, 16'd16);
    check("done_cnt0", sample_cnt, 0);
    pulse(16'd2, 16'd2, 16'd2);
    check("new_win_cnt", sample_cnt, 1);
    check("level_avg", avg_x, 16'd16);
    accept();

`ifdef ACCEL_STALE_EN
    tick(105);
    check("stale_set", stale, 1);
    data_update = 1'b1;
    tick();
    data_update = 1'b0;
    check("stale_clr", stale, 0);
    tick();
`endif

    repeat (N - 2) pulse(16'd12, 16'd12, 16'd12);
    pulse(16'd12, 16'd12, 16'd12);
    pulse(16'd12, 16'd12, 16'd12);
    check("pre_reset_valid", avg_valid, 1);
    pulse(16'd7, 16'd7, 16'd7);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_reset", {avg_x, avg_y, avg_z, avg_valid, overrun, sample_cnt}, 0);
    tick();
    reset_n = 1'b1;
    tick(3);
    pulse(16'd3, 16'd3, 16'd3);
    check("post_reset_cnt", sample_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
